// File: rtl/axi_test_reg_cfg_seq_pkg.sv
// Shared types, constants and the writable-field mask for axi_test_reg_cfg_seq.
// The RD/RRESP states exist only when AXI_TEST_REG_CFG_SEQ_VERIFY_EN is defined.
package axi_test_reg_cfg_seq_pkg;

  localparam int MAX_ENTRIES = 16;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Register map of the axi_test_reg block (offsets and writable bits).
  localparam logic [7:0]  REG_CTRL_OFFSET   = 8'h00;
  localparam logic [7:0]  REG_ENABLE_OFFSET = 8'h04;
  localparam logic [7:0]  REG_CFG_OFFSET    = 8'h08;
  localparam logic [31:0] REG_CTRL_MASK     = 32'h0001_FFFF;
  localparam logic [31:0] REG_ENABLE_MASK   = 32'h0000_0001;
  localparam logic [31:0] REG_CFG_MASK      = 32'h000F_FF0F;

`ifdef AXI_TEST_REG_CFG_SEQ_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_RD, S_RRESP, S_DONE} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_DONE} state_e;
`endif

  function automatic logic [31:0] field_mask(input logic [7:0] offset);
    case (offset)
      REG_CTRL_OFFSET:   field_mask = REG_CTRL_MASK;
      REG_ENABLE_OFFSET: field_mask = REG_ENABLE_MASK;
      REG_CFG_OFFSET:    field_mask = REG_CFG_MASK;
      default:           field_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/axi_test_reg_cfg_seq.sv
// AXI4-Lite master that writes a table of offset/data pairs into axi_test_reg after a start pulse.
// Define AXI_TEST_REG_CFG_SEQ_VERIFY_EN to read back and check each writable field.
module axi_test_reg_cfg_seq
  import axi_test_reg_cfg_seq_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [NUM_ENTRIES*8-1:0] i_entry_offset,
  input  logic [NUM_ENTRIES*32-1:0] i_entry_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic                     o_awvalid,
  input  logic                     i_awready,
  output logic [ADDR_WIDTH-1:0]    o_awaddr,
  output logic                     o_wvalid,
  input  logic                     i_wready,
  output logic [DATA_WIDTH-1:0]    o_wdata,
  input  logic                     i_bvalid,
  output logic                     o_bready,
  input  logic [1:0]               i_bresp,
  output logic                     o_arvalid,
  input  logic                     i_arready,
  output logic [ADDR_WIDTH-1:0]    o_araddr,
  input  logic                     i_rvalid,
  output logic                     o_rready,
  input  logic [DATA_WIDTH-1:0]    i_rdata,
  input  logic [1:0]               i_rresp
);

  localparam int         OFF_W    = MAX_ENTRIES * 8;
  localparam int         DAT_W    = MAX_ENTRIES * 32;
  localparam logic [3:0] LAST_IDX = 4'(NUM_ENTRIES - 1);

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             err_q, err_d;
  logic             aw_ok_q, aw_ok_d;
  logic             w_ok_q, w_ok_d;
  logic             load;
  logic [OFF_W-1:0] off_q;
  logic [DAT_W-1:0] dat_q;
  logic [7:0]       cur_off;
  logic [31:0]      cur_dat;
  logic             aw_hs, w_hs, last;

  // Table is widened to 16 slots so the 4-bit index always selects in range.
  always_ff @(posedge i_clk) begin
    if (load) begin
      off_q <= OFF_W'(i_entry_offset);
      dat_q <= DAT_W'(i_entry_data);
    end
  end

  assign cur_off = off_q[{idx_q, 3'b000} +: 8];
  assign cur_dat = dat_q[{idx_q, 5'b00000} +: 32];
  assign last    = (idx_q == LAST_IDX);
  assign aw_hs   = o_awvalid && i_awready;
  assign w_hs    = o_wvalid && i_wready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      aw_ok_q <= 1'b0;
      w_ok_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      aw_ok_q <= aw_ok_d;
      w_ok_q  <= w_ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    aw_ok_d = aw_ok_q;
    w_ok_d  = w_ok_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_WR;
          idx_d   = '0;
          err_d   = 1'b0;
          load    = 1'b1;
        end
      end
      S_WR: begin
        if (aw_hs) aw_ok_d = 1'b1;
        if (w_hs)  w_ok_d  = 1'b1;
        if ((aw_ok_q || aw_hs) && (w_ok_q || w_hs)) state_d = S_WRESP;
      end
      S_WRESP: begin
        // Handshake flags are only meaningful in WR; clearing here arms the next entry.
        aw_ok_d = 1'b0;
        w_ok_d  = 1'b0;
        if (i_bvalid) begin
          if (i_bresp != RESP_OKAY) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
`ifdef AXI_TEST_REG_CFG_SEQ_VERIFY_EN
            state_d = S_RD;
`else
            if (last) state_d = S_DONE;
            else begin
              state_d = S_WR;
              idx_d   = idx_q + 4'd1;
            end
`endif
          end
        end
      end
`ifdef AXI_TEST_REG_CFG_SEQ_VERIFY_EN
      S_RD: begin
        if (i_arready) state_d = S_RRESP;
      end
      S_RRESP: begin
        if (i_rvalid) begin
          if ((i_rresp != RESP_OKAY) ||
              (((32'(i_rdata) ^ cur_dat) & field_mask(cur_off)) != 32'h0)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WR;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = (state_q == S_DONE);
  assign o_error   = err_q;
  assign o_awvalid = (state_q == S_WR) && !aw_ok_q;
  assign o_wvalid  = (state_q == S_WR) && !w_ok_q;
  assign o_bready  = (state_q == S_WRESP);
  assign o_awaddr  = o_awvalid ? ADDR_WIDTH'(cur_off) : '0;
  assign o_wdata   = o_wvalid ? DATA_WIDTH'(cur_dat) : '0;

`ifdef AXI_TEST_REG_CFG_SEQ_VERIFY_EN
  assign o_arvalid = (state_q == S_RD);
  assign o_rready  = (state_q == S_RRESP);
  assign o_araddr  = o_arvalid ? ADDR_WIDTH'(cur_off) : '0;
`else
  logic unused_rd;
  assign unused_rd = ^{i_arready, i_rvalid, i_rdata, i_rresp};
  assign o_arvalid = 1'b0;
  assign o_rready  = 1'b0;
  assign o_araddr  = '0;
`endif

endmodule

// File: tb/tb_axi_test_reg_cfg_seq.sv
// Self-checking bench for axi_test_reg_cfg_seq: behavioural AXI4-Lite slave plus a
// transaction-level model of the expected writes, reads, error and completion cycle.
`timescale 1ns/1ps
module tb_axi_test_reg_cfg_seq;

  localparam int NE = 3;
`ifdef AXI_TEST_REG_CFG_SEQ_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start;
  logic [NE*8-1:0]  ent_off;
  logic [NE*32-1:0] ent_dat;
  logic busy, done, error;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [7:0]  awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_test_reg_cfg_seq #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_ENTRIES(NE)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_entry_offset(ent_off), .i_entry_data(ent_dat),
    .o_busy(busy), .o_done(done), .o_error(error),
    .o_awvalid(awvalid), .i_awready(awready), .o_awaddr(awaddr),
    .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata),
    .i_bvalid(bvalid), .o_bready(bready), .i_bresp(bresp),
    .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr),
    .i_rvalid(rvalid), .o_rready(rready), .i_rdata(rdata), .i_rresp(rresp)
  );

  // Slave knobs, driven from tasks only
  int aw_delay, w_delay, b_err_at, r_err_at, r_flip_at;
  logic [31:0] r_flip_val;
  logic slv_clr;

  // Slave state, written by the slave process only
  int aw_cnt, w_cnt, n_b, n_r;
  logic [7:0]  aw_addr_q, ar_addr_q;
  logic [31:0] w_data_q;
  logic [31:0] mem [256];
  logic [7:0]  wlog_addr [64];
  logic [31:0] wlog_data [64];
  logic [7:0]  rlog_addr [64];

  assign awready = (aw_cnt >= aw_delay);
  assign wready  = (w_cnt >= w_delay);
  assign bvalid  = 1'b1;
  assign arready = 1'b1;
  assign rvalid  = 1'b1;
  assign bresp   = (n_b == b_err_at) ? 2'b10 : 2'b00;
  assign rresp   = (n_r == r_err_at) ? 2'b10 : 2'b00;
  assign rdata   = mem[ar_addr_q] ^ ((n_r == r_flip_at) ? r_flip_val : 32'h0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0;
      w_cnt  <= 0;
    end else if (slv_clr) begin
      aw_cnt <= 0; w_cnt <= 0; n_b <= 0; n_r <= 0;
    end else begin
      if (awvalid && awready) begin aw_addr_q <= awaddr; aw_cnt <= 0; end
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin w_data_q <= wdata; w_cnt <= 0; end
      else if (wvalid) w_cnt <= w_cnt + 1;
      if (bvalid && bready && n_b < 64) begin
        mem[aw_addr_q]  <= w_data_q;
        wlog_addr[n_b]  <= aw_addr_q;
        wlog_data[n_b]  <= w_data_q;
        n_b <= n_b + 1;
      end
      if (arvalid && arready) ar_addr_q <= araddr;
      if (rvalid && rready && n_r < 64) begin
        rlog_addr[n_r] <= ar_addr_q;
        n_r <= n_r + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Table, model expectations and observed results
  logic [7:0]  t_off [16];
  logic [31:0] t_dat [16];
  int exp_writes, exp_reads, exp_done_cyc;
  bit exp_err;
  int got_done_cyc;
  logic got_err, got_busy_after;
  logic tr_awv [256];
  logic tr_wv  [256];
  logic tr_br  [256];

  function automatic logic [31:0] exp_mask(input logic [7:0] off);
    case (off)
      8'h00:   return 32'h0001_FFFF;
      8'h04:   return 32'h0000_0001;
      8'h08:   return 32'h000F_FF0F;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic clear_knobs();
    aw_delay = 0; w_delay = 0; b_err_at = -1; r_err_at = -1; r_flip_at = -1;
    r_flip_val = 32'h0;
  endtask

  task automatic set_spec_table();
    t_off[0] = 8'h00; t_dat[0] = 32'h0001_2345;
    t_off[1] = 8'h04; t_dat[1] = 32'h0000_0001;
    t_off[2] = 8'h08; t_dat[2] = 32'h000A_BC0D;
  endtask

  // Entry-level expectation: each write costs the slower of AW/W plus one WR cycle
  // and one response cycle; each readback costs two cycles; the first error ends it.
  task automatic model();
    int cyc;
    logic [31:0] rb;
    cyc = 1; exp_writes = 0; exp_reads = 0; exp_err = 1'b0;
    for (int k = 0; k < NE; k++) begin
      cyc += ((aw_delay > w_delay) ? aw_delay : w_delay) + 2;
      exp_writes++;
      if (k == b_err_at) begin exp_err = 1'b1; break; end
      if (VERIFY) begin
        cyc += 2;
        exp_reads++;
        rb = t_dat[k] ^ ((k == r_flip_at) ? r_flip_val : 32'h0);
        if (k == r_err_at || ((rb ^ t_dat[k]) & exp_mask(t_off[k])) != 32'h0) begin
          exp_err = 1'b1;
          break;
        end
      end
    end
    exp_done_cyc = cyc;
  endtask

  task automatic run_seq(input int extra_start_cyc, input bit start_in_done);
    int cyc;
    @(negedge clk);
    for (int k = 0; k < NE; k++) begin
      ent_off[k*8 +: 8]   = t_off[k];
      ent_dat[k*32 +: 32] = t_dat[k];
    end
    slv_clr = 1'b1;
    @(negedge clk);
    slv_clr = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; got_done_cyc = -1; got_err = 1'b0;
    while (cyc < 250) begin
      tr_awv[cyc] = awvalid; tr_wv[cyc] = wvalid; tr_br[cyc] = bready;
      if (done) begin
        got_done_cyc = cyc; got_err = error; start = start_in_done;
        break;
      end
      start = (cyc == extra_start_cyc);
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    start = 1'b0;
    got_busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; slv_clr = 1'b0; ent_off = '0; ent_dat = '0;
    clear_knobs();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, error, awvalid, wvalid, bready, arvalid, rready} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {busy, done, error, awvalid, wvalid, bready, arvalid, rready});
    end
    n_tests++;
    if ({awaddr, araddr} !== 16'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h required 0000", {awaddr, araddr});
    end
    n_tests++;
    if (wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_wdata: got %h required 0", wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spec_table();
    clear_knobs(); set_spec_table(); model();
    run_seq(-1, 1'b0);
    n_tests++;
    if (got_done_cyc != (VERIFY ? 13 : 7)) begin
      n_fail++; $display("FAIL spec_done_cycle: got %0d required %0d", got_done_cyc, VERIFY ? 13 : 7);
    end
    n_tests++;
    if (got_err !== 1'b0) begin n_fail++; $display("FAIL spec_error: got %b required 0", got_err); end
    n_tests++;
    if (n_b != 3) begin n_fail++; $display("FAIL spec_writes: got %0d required 3", n_b); end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (wlog_addr[k] !== t_off[k] || wlog_data[k] !== t_dat[k]) begin
        n_fail++;
        $display("FAIL spec_write%0d: got %h:%h required %h:%h", k, wlog_addr[k], wlog_data[k], t_off[k], t_dat[k]);
      end
    end
    n_tests++;
    if (n_r != exp_reads) begin n_fail++; $display("FAIL spec_reads: got %0d required %0d", n_r, exp_reads); end
    for (int k = 0; k < exp_reads; k++) begin
      n_tests++;
      if (rlog_addr[k] !== t_off[k]) begin
        n_fail++; $display("FAIL spec_read%0d: got %h required %h", k, rlog_addr[k], t_off[k]);
      end
    end
    n_tests++;
    if (got_busy_after !== 1'b0) begin n_fail++; $display("FAIL spec_idle_after: busy %b required 0", got_busy_after); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      clear_knobs();
      for (int k = 0; k < NE; k++) begin
        case ($urandom_range(0, 3))
          0: t_off[k] = 8'h00;
          1: t_off[k] = 8'h04;
          2: t_off[k] = 8'h08;
          default: t_off[k] = 8'($urandom);
        endcase
        t_dat[k] = $urandom;
      end
      aw_delay = int'($urandom_range(0, 3));
      w_delay  = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) b_err_at = int'($urandom_range(0, NE - 1));
      if ($urandom_range(0, 3) == 0) r_err_at = int'($urandom_range(0, NE - 1));
      if ($urandom_range(0, 1) == 0) begin
        r_flip_at  = int'($urandom_range(0, NE - 1));
        r_flip_val = ($urandom_range(0, 1) == 0) ? $urandom : (32'h1 << $urandom_range(0, 31));
      end
      model();
      run_seq(-1, 1'b0);
      n_tests++;
      if (got_done_cyc != exp_done_cyc) begin
        n_fail++; $display("FAIL rand%0d_done_cycle: got %0d required %0d", it, got_done_cyc, exp_done_cyc);
      end
      n_tests++;
      if (got_err !== exp_err) begin
        n_fail++; $display("FAIL rand%0d_error: got %b required %b", it, got_err, exp_err);
      end
      n_tests++;
      if (n_b != exp_writes || n_r != exp_reads) begin
        n_fail++;
        $display("FAIL rand%0d_counts: got w%0d r%0d required w%0d r%0d", it, n_b, n_r, exp_writes, exp_reads);
      end
      for (int k = 0; k < exp_writes; k++) begin
        n_tests++;
        if (wlog_addr[k] !== t_off[k] || wlog_data[k] !== t_dat[k]) begin
          n_fail++;
          $display("FAIL rand%0d_write%0d: got %h:%h required %h:%h", it, k, wlog_addr[k], wlog_data[k], t_off[k], t_dat[k]);
        end
      end
    end
  endtask

  task automatic test_aw_delay();
    clear_knobs(); set_spec_table(); aw_delay = 3; model();
    run_seq(-1, 1'b0);
    n_tests++;
    if ({tr_awv[1], tr_awv[2], tr_awv[3], tr_awv[4], tr_awv[5]} !== 5'b11110) begin
      n_fail++; $display("FAIL awdly_awvalid: got %b required 11110", {tr_awv[1], tr_awv[2], tr_awv[3], tr_awv[4], tr_awv[5]});
    end
    n_tests++;
    if ({tr_wv[1], tr_wv[2]} !== 2'b10) begin
      n_fail++; $display("FAIL awdly_wvalid: got %b required 10", {tr_wv[1], tr_wv[2]});
    end
    n_tests++;
    if ({tr_br[1], tr_br[2], tr_br[3], tr_br[4], tr_br[5]} !== 5'b00001) begin
      n_fail++; $display("FAIL awdly_bready: got %b required 00001", {tr_br[1], tr_br[2], tr_br[3], tr_br[4], tr_br[5]});
    end
    n_tests++;
    if (got_done_cyc != exp_done_cyc || got_err !== 1'b0) begin
      n_fail++; $display("FAIL awdly_done: got cyc %0d err %b required cyc %0d err 0", got_done_cyc, got_err, exp_done_cyc);
    end
  endtask

  task automatic test_bresp_err();
    bit saw08;
    clear_knobs(); set_spec_table(); b_err_at = 1; model();
    run_seq(-1, 1'b0);
    n_tests++;
    if (got_err !== 1'b1) begin n_fail++; $display("FAIL bresp_error: got %b required 1", got_err); end
    n_tests++;
    if (got_done_cyc != exp_done_cyc) begin
      n_fail++; $display("FAIL bresp_done_cycle: got %0d required %0d", got_done_cyc, exp_done_cyc);
    end
    saw08 = 1'b0;
    for (int k = 0; k < n_b && k < 64; k++) if (wlog_addr[k] == 8'h08) saw08 = 1'b1;
    n_tests++;
    if (n_b != 2 || saw08) begin
      n_fail++; $display("FAIL bresp_skip: got %0d writes (offset08 seen %b) required 2 writes, none to 08", n_b, saw08);
    end
  endtask

  task automatic test_readback();
    logic [31:0] flips [2];
    flips[0] = 32'hFFFE_0000;
    flips[1] = 32'h0000_0001;
    for (int i = 0; i < 2; i++) begin
      clear_knobs(); set_spec_table(); r_flip_at = 0; r_flip_val = flips[i]; model();
      run_seq(-1, 1'b0);
      n_tests++;
      if (got_err !== exp_err || got_done_cyc != exp_done_cyc) begin
        n_fail++;
        $display("FAIL readback_flip%0d: got err %b cyc %0d required err %b cyc %0d", i, got_err, got_done_cyc, exp_err, exp_done_cyc);
      end
    end
  endtask

  task automatic test_start_ignored();
    int extra_done;
    clear_knobs(); set_spec_table(); model();
    run_seq(3, 1'b1);
    extra_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) extra_done++;
      @(negedge clk);
    end
    n_tests++;
    if (got_done_cyc != exp_done_cyc) begin
      n_fail++; $display("FAIL ignore_done_cycle: got %0d required %0d", got_done_cyc, exp_done_cyc);
    end
    n_tests++;
    if (extra_done != 0 || n_b != NE) begin
      n_fail++; $display("FAIL ignore_once: got %0d active cycles after, %0d writes required 0 and %0d", extra_done, n_b, NE);
    end
  endtask

  task automatic test_reset_mid();
    clear_knobs(); set_spec_table(); aw_delay = 2;
    @(negedge clk);
    for (int k = 0; k < NE; k++) begin
      ent_off[k*8 +: 8] = t_off[k]; ent_dat[k*32 +: 32] = t_dat[k];
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (awvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: awvalid %b required 1", awvalid); end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, error, awvalid, wvalid, bready, arvalid, rready, awaddr, wdata} !== 48'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b %h %h required all zero",
               {busy, done, error, awvalid, wvalid, bready, arvalid, rready}, awaddr, wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_knobs(); model();
    run_seq(-1, 1'b0);
    n_tests++;
    if (got_done_cyc != exp_done_cyc || got_err !== 1'b0 || n_b != NE) begin
      n_fail++;
      $display("FAIL rstmid_rerun: got cyc %0d err %b writes %0d required cyc %0d err 0 writes %0d",
               got_done_cyc, got_err, n_b, exp_done_cyc, NE);
    end
    n_tests++;
    if (wlog_addr[0] !== t_off[0] || wlog_data[0] !== t_dat[0]) begin
      n_fail++; $display("FAIL rstmid_entry0: got %h:%h required %h:%h", wlog_addr[0], wlog_data[0], t_off[0], t_dat[0]);
    end
  endtask

  initial begin
    test_reset();
    test_spec_table();
    test_aw_delay();
    test_bresp_err();
    test_readback();
    test_start_ignored();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
